// File: rtl/equiv_pkg.sv
// Shared types for the equivalence mismatch monitor.
package equiv_pkg;

  localparam int EQ_WIDTH = 91;

  typedef enum logic [2:0] {
    IDLE,
    WARMUP,
    COMPARE,
    DRAIN,
    PASS,
    FAIL
  } state_e;

endpackage

// File: rtl/equiv_diff_stage.sv
// One-deep registered compare stage: holds y_1^y_2 of the sample taken at the
// previous edge, its window flag and its compare index. flush drops the sample.
module equiv_diff_stage #(
  parameter int WIDTH = 91,
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             take,
  input  logic [WIDTH-1:0] diff_d,
  input  logic [IDX_W-1:0] idx_d,
  output logic [WIDTH-1:0] diff_q,
  output logic             win_q,
  output logic [IDX_W-1:0] idx_q
);

  // Register the sample; flush wins over take so a stopped run sees nothing more.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      win_q  <= 1'b0;
      diff_q <= '0;
      idx_q  <= '0;
    end else begin
      win_q <= take;
      if (take) begin
        diff_q <= diff_d;
        idx_q  <= idx_d;
      end
    end
  end

endmodule

// File: rtl/equiv_mismatch_monitor.sv
// Run-controlled checker for the dual-instance equivalence harness: warm-up,
// bounded compare window, sticky verdict, saturating count, first-fail capture.
module equiv_mismatch_monitor
  import equiv_pkg::*;
#(
  parameter int WIDTH         = EQ_WIDTH,
  parameter int WARMUP_CYCLES = 4,
  parameter int MAX_CYCLES    = 1024,
  parameter int CNT_W         = 16,
  parameter bit STOP_ON_FAIL  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] y_1,
  input  logic [WIDTH-1:0] y_2,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] first_idx,
  output logic [WIDTH-1:0] first_diff
);

  // Sample counter is sized from MAX_CYCLES so a narrow CNT_W only narrows the
  // reported values, never the window length.
  localparam int SCW_MIN   = $clog2(MAX_CYCLES + 1);
  localparam int SCW       = (CNT_W > SCW_MIN) ? CNT_W : SCW_MIN;
  localparam int WW        = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam int WARM_LAST = (WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0;
  localparam int SAMP_LAST = (MAX_CYCLES > 0) ? MAX_CYCLES - 1 : 0;

  state_e           state;
  logic [SCW-1:0]   sample_cnt;
  logic [WW-1:0]    warm_cnt;
  logic [WIDTH-1:0] diff_q;
  logic             win_q;
  logic [SCW-1:0]   idx_q;
  logic             mism;
  logic             flush;
  logic             take;

  // Evaluation of the registered sample and the stop-on-fail flush.
  assign mism  = win_q && (|diff_q);
  assign flush = STOP_ON_FAIL && mism;
  assign take  = (state == COMPARE) && !flush;
  assign busy  = (state == WARMUP) || (state == COMPARE) || (state == DRAIN);

  equiv_diff_stage #(
    .WIDTH (WIDTH),
    .IDX_W (SCW)
  ) u_diff (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .take   (take),
    .diff_d (y_1 ^ y_2),
    .idx_d  (sample_cnt),
    .diff_q (diff_q),
    .win_q  (win_q),
    .idx_q  (idx_q)
  );

  // Run FSM plus verdict/capture registers; start-clears are written after the
  // evaluation so they take precedence (win_q is never set outside a run anyway).
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sample_cnt   <= '0;
      warm_cnt     <= '0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      mismatch_cnt <= '0;
      first_idx    <= '0;
      first_diff   <= '0;
    end else begin
      if (mism) begin
        if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
        if (!fail) begin
          first_diff <= diff_q;
          first_idx  <= idx_q[CNT_W-1:0];
          fail       <= 1'b1;
        end
      end
      case (state)
        IDLE, PASS, FAIL: begin
          if (start) begin
            state        <= (WARMUP_CYCLES == 0) ? COMPARE : WARMUP;
            sample_cnt   <= '0;
            warm_cnt     <= '0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            mismatch_cnt <= '0;
            first_idx    <= '0;
            first_diff   <= '0;
          end
        end
        WARMUP: begin
          if (warm_cnt == WW'(WARM_LAST)) state <= COMPARE;
          else                            warm_cnt <= warm_cnt + WW'(1);
        end
        COMPARE: begin
          sample_cnt <= sample_cnt + SCW'(1);
          if (flush)                                 state <= FAIL;
          else if (sample_cnt == SCW'(SAMP_LAST))    state <= DRAIN;
        end
        DRAIN: begin
          if (fail || mism) begin
            state <= FAIL;
          end else begin
            state <= PASS;
            pass  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_equiv_mismatch_monitor.sv
// Bench for equiv_mismatch_monitor: three parameterisations, directed and
// randomized runs checked against a window-level reference model.
module tb_equiv_mismatch_monitor;
  localparam int W = 91;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [2:0]    start;
  logic [W-1:0]  y_1, y_2;

  logic          busy_a, pass_a, fail_a, busy_b, pass_b, fail_b, busy_c, pass_c, fail_c;
  logic [15:0]   cnt_a, idx_a, cnt_b, idx_b;
  logic [1:0]    cnt_c, idx_c;
  logic [W-1:0]  diff_a, diff_b, diff_c;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] dv [0:63];

  // A: stop on fail, B: full window, C: no warm-up and a 2-bit counter
  equiv_mismatch_monitor #(.WIDTH(W), .WARMUP_CYCLES(4), .MAX_CYCLES(8), .CNT_W(16), .STOP_ON_FAIL(1'b1)) u_a (
    .clk(clk), .rst(rst), .start(start[0]), .y_1(y_1), .y_2(y_2), .busy(busy_a), .pass(pass_a),
    .fail(fail_a), .mismatch_cnt(cnt_a), .first_idx(idx_a), .first_diff(diff_a));
  equiv_mismatch_monitor #(.WIDTH(W), .WARMUP_CYCLES(4), .MAX_CYCLES(8), .CNT_W(16), .STOP_ON_FAIL(1'b0)) u_b (
    .clk(clk), .rst(rst), .start(start[1]), .y_1(y_1), .y_2(y_2), .busy(busy_b), .pass(pass_b),
    .fail(fail_b), .mismatch_cnt(cnt_b), .first_idx(idx_b), .first_diff(diff_b));
  equiv_mismatch_monitor #(.WIDTH(W), .WARMUP_CYCLES(0), .MAX_CYCLES(8), .CNT_W(2), .STOP_ON_FAIL(1'b0)) u_c (
    .clk(clk), .rst(rst), .start(start[2]), .y_1(y_1), .y_2(y_2), .busy(busy_c), .pass(pass_c),
    .fail(fail_c), .mismatch_cnt(cnt_c), .first_idx(idx_c), .first_diff(diff_c));

  // what: 0 busy, 1 pass, 2 fail, 3 count, 4 first_idx, 5 first_diff
  function automatic logic [W-1:0] get(input int sel, input int what);
    logic [W-1:0] r;
    r = '0;
    case (sel)
      0: case (what) 0: r = W'(busy_a); 1: r = W'(pass_a); 2: r = W'(fail_a);
                     3: r = W'(cnt_a);  4: r = W'(idx_a);  default: r = diff_a; endcase
      1: case (what) 0: r = W'(busy_b); 1: r = W'(pass_b); 2: r = W'(fail_b);
                     3: r = W'(cnt_b);  4: r = W'(idx_b);  default: r = diff_b; endcase
      default: case (what) 0: r = W'(busy_c); 1: r = W'(pass_c); 2: r = W'(fail_c);
                     3: r = W'(cnt_c);  4: r = W'(idx_c);  default: r = diff_c; endcase
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] d);
    logic [95:0] r;
    r   = {$urandom, $urandom, $urandom};
    y_1 = r[W-1:0];
    y_2 = r[W-1:0] ^ d;
  endtask

  function automatic logic [W-1:0] rbit();
    logic [W-1:0] m;
    m = '0;
    m[$urandom_range(0, W-1)] = 1'b1;
    return m;
  endfunction

  task automatic clr_dv();
    for (int i = 0; i < 64; i++) dv[i] = '0;
  endtask

  // dv[j] is the y_1^y_2 presented before edge j, edge 0 being the start edge.
  task automatic run_case(input string tag, input int sel, input int warm, input int maxc,
                          input bit stop, input int cntw, input bit mid_start);
    int f, cnt, endedge, busy_n, fedge, satv;
    bit anym;
    logic [W-1:0] fd;
    // reference: walk the compare window sample by sample
    f = 0; cnt = 0; anym = 1'b0; fd = '0;
    for (int s = 0; s < maxc; s++) begin
      if (dv[warm + 1 + s] != '0) begin
        if (!anym) begin f = s; fd = dv[warm + 1 + s]; anym = 1'b1; end
        cnt++;
        if (stop) break;
      end
    end
    satv = (1 << cntw) - 1;
    if (cnt > satv) cnt = satv;
    endedge = (stop && anym) ? warm + 2 + f : warm + maxc + 1;

    busy_n = 0; fedge = -1;
    @(negedge clk); drive('0); start[sel] = 1'b1;
    @(posedge clk); #1;
    if (get(sel, 0) == 1) busy_n++;
    if (get(sel, 2) == 1 && fedge < 0) fedge = 0;
    for (int j = 1; j <= endedge + 1; j++) begin
      @(negedge clk); start[sel] = mid_start && (j == 3); drive(dv[j]);
      @(posedge clk); #1;
      if (get(sel, 0) == 1) busy_n++;
      if (get(sel, 2) == 1 && fedge < 0) fedge = j;
    end
    @(negedge clk); start = '0;
    chk({tag, ".busy_cycles"}, W'(busy_n), W'(endedge));
    chk({tag, ".fail_edge"}, W'(fedge), anym ? W'(warm + 2 + f) : W'(-1));
    chk({tag, ".busy"}, get(sel, 0), '0);
    chk({tag, ".pass"}, get(sel, 1), W'(!anym));
    chk({tag, ".fail"}, get(sel, 2), W'(anym));
    chk({tag, ".cnt"}, get(sel, 3), W'(cnt));
    if (anym) begin
      chk({tag, ".first_idx"}, get(sel, 4), W'(f & satv));
      chk({tag, ".first_diff"}, get(sel, 5), fd);
    end
  endtask

  initial begin
    logic [W-1:0] one;
    one = '0; one[0] = 1'b1;
    rst = 1'b1; start = '0; drive('0);
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("reset.busy", get(s, 0), '0);
      chk("reset.pass", get(s, 1), '0);
      chk("reset.fail", get(s, 2), '0);
      chk("reset.cnt",  get(s, 3), '0);
    end
    @(negedge clk); rst = 1'b0;

    // reset in the middle of a run that has already counted a mismatch
    clr_dv(); dv[6] = rbit();
    @(negedge clk); start[1] = 1'b1; drive('0);
    for (int j = 1; j < 10; j++) begin
      @(negedge clk); start = '0; drive(dv[j]);
    end
    @(posedge clk); #1;
    chk("midrst.busy_before", W'(busy_b), W'(1));
    chk("midrst.cnt_before", W'(cnt_b), W'(1));
    @(negedge clk); rst = 1'b1; drive('0);
    @(posedge clk); #1;
    chk("midrst.busy", W'(busy_b), '0);
    chk("midrst.fail", W'(fail_b), '0);
    chk("midrst.cnt", W'(cnt_b), '0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst.busy_after", W'(busy_b), '0);
    chk("midrst.pass_after", W'(pass_b), '0);
    chk("midrst.fail_after", W'(fail_b), '0);
    chk("midrst.cnt_after", W'(cnt_b), '0);

    clr_dv();
    run_case("clean", 0, 4, 8, 1'b1, 16, 1'b0);

    clr_dv(); dv[2] = one;
    run_case("warmup_diff", 0, 4, 8, 1'b1, 16, 1'b0);

    clr_dv(); dv[4 + 1 + 5] = one << 90; dv[4 + 1 + 6] = rbit();
    run_case("stop_s5", 0, 4, 8, 1'b1, 16, 1'b0);

    clr_dv(); dv[4 + 1 + 3] = rbit(); dv[4 + 1 + 7] = rbit();
    run_case("full_s3_s7", 1, 4, 8, 1'b0, 16, 1'b0);

    clr_dv();
    foreach (dv[k]) if (k inside {1, 3, 4, 6, 7, 8}) dv[k] = rbit();
    run_case("sat_midstart", 2, 0, 8, 1'b0, 2, 1'b1);

    for (int r = 0; r < 6; r++) begin
      clr_dv();
      for (int j = 1; j < 16; j++) if ($urandom_range(0, 3) == 0) dv[j] = rbit() | rbit();
      case (r % 3)
        0: run_case("rand_a", 0, 4, 8, 1'b1, 16, 1'b0);
        1: run_case("rand_b", 1, 4, 8, 1'b0, 16, 1'b0);
        default: run_case("rand_c", 2, 0, 8, 1'b0, 2, 1'b0);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
